// File: rtl/svm_param_memories.sv
// Support-vector and per-channel alpha storage for the SVM datapath.
// Rows are loaded through a handshaked sequential write port and read back as a 2-deep buffered stream.
module svm_param_memories #(
  parameter int unsigned           NBITS        = 9,
  parameter int unsigned           NUM_CH       = 2,
  parameter int unsigned           FEATS        = 155,
  parameter int unsigned           NUM_SV       = 214,
  parameter logic [NUM_CH*16-1:0]  ALPHA_DEPTHS = {16'd155, 16'd120},
  parameter int unsigned           LOG_SV       = $clog2(NUM_SV)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          abort,
  input  logic                          load_start,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [NUM_CH*FEATS*NBITS-1:0] wr_support,
  input  logic [NUM_CH*NBITS-1:0]       wr_alpha,
  output logic                          load_done,
  input  logic                          rd_start,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [LOG_SV-1:0]             rd_index,
  output logic [NUM_CH*FEATS*NBITS-1:0] rd_support,
  output logic [NUM_CH*NBITS-1:0]       rd_alpha,
  output logic                          rd_last,
  output logic                          busy
);

  localparam int unsigned       ROW_W     = NUM_CH * FEATS * NBITS;
  localparam int unsigned       CMP_W     = LOG_SV + 1;
  localparam logic [LOG_SV-1:0] LAST_ADDR = LOG_SV'(NUM_SV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [LOG_SV-1:0] wr_addr_q, wr_addr_d;
  logic [LOG_SV-1:0] rd_addr_q, rd_addr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ready_q, wr_ready_d;
  logic              load_done_q, load_done_d;
  logic              busy_q, busy_d;

  logic wr_fire;
  logic issue;
  logic pop;
  logic buf_valid;

  logic [ROW_W-1:0]  support_mem [NUM_SV];
  logic [ROW_W-1:0]  buf_support [2];
  logic [LOG_SV-1:0] buf_index   [2];
  logic              buf_last    [2];

  assign buf_valid = (count_q != 2'd0);
  assign wr_fire   = wr_valid && wr_ready_q;
  assign pop       = buf_valid && rd_ready;
  // Read data lands in the buffer at the issue edge, so nothing is ever in flight when deciding.
  assign issue     = (state_q == STREAM) && (count_q < 2'd2) && !abort;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    load_done_d = 1'b0;
    wr_ready_d  = 1'b0;
    busy_d      = 1'b0;

    if (issue) wr_ptr_d = ~wr_ptr_q;
    if (pop)   rd_ptr_d = ~rd_ptr_q;
    case ({issue, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = LOAD;
          wr_addr_d = '0;
        end else if (rd_start) begin
          state_d   = STREAM;
          rd_addr_d = '0;
        end
      end
      LOAD: begin
        if (wr_fire) begin
          wr_addr_d = wr_addr_q + LOG_SV'(1);
          if (wr_addr_q == LAST_ADDR) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + LOG_SV'(1);
          if (rd_addr_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_d == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything and flushes the output buffer.
    if (abort) begin
      state_d     = IDLE;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      count_d     = 2'd0;
      load_done_d = 1'b0;
    end

    wr_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      wr_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ready_q  <= wr_ready_d;
      load_done_q <= load_done_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) support_mem[wr_addr_q] <= wr_support;
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      buf_support[wr_ptr_q] <= support_mem[rd_addr_q];
      buf_index[wr_ptr_q]   <= rd_addr_q;
      buf_last[wr_ptr_q]    <= (rd_addr_q == LAST_ADDR);
    end
  end

  // Each channel keeps its own alpha array; indices past its depth never write and read back as zero.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [CMP_W-1:0] DEPTH = CMP_W'(ALPHA_DEPTHS[c*16 +: 16]);

    logic [NBITS-1:0] alpha_mem [NUM_SV];
    logic [NBITS-1:0] buf_alpha [2];
    logic             wr_in_range;
    logic             rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH);
    assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH);

    always_ff @(posedge clk) begin
      if (wr_fire && wr_in_range) alpha_mem[wr_addr_q] <= wr_alpha[c*NBITS +: NBITS];
    end

    always_ff @(posedge clk) begin
      if (issue) buf_alpha[wr_ptr_q] <= rd_in_range ? alpha_mem[rd_addr_q] : '0;
    end

    assign rd_alpha[c*NBITS +: NBITS] = buf_valid ? buf_alpha[rd_ptr_q] : '0;
  end

  assign wr_ready   = wr_ready_q;
  assign load_done  = load_done_q;
  assign busy       = busy_q;
  assign rd_valid   = buf_valid;
  assign rd_index   = buf_valid ? buf_index[rd_ptr_q]   : '0;
  assign rd_support = buf_valid ? buf_support[rd_ptr_q] : '0;
  assign rd_last    = buf_valid ? buf_last[rd_ptr_q]    : 1'b0;

endmodule

// File: doc/svm_param_memories.md
Name: svm_param_memories

Overview:
- Parametrised storage for SVM support vectors and alpha coefficients across NUM_CH sensor channels.
- Successor to the fixed two-channel SVM memory bank.
- Adds a handshaked sequential load port, a streaming read port with backpressure, per-channel alpha depths and an abort control.
- Sits between the off-chip parameter loader and the SVM kernel/accumulate datapath.

Parameters:
- NBITS, 9: signed word width.
- NUM_CH, 2: number of channels.
- FEATS, 155: feature words per support vector per channel. Narrower channels zero-pad their upper words.
- NUM_SV, 214: number of support vectors (memory depth).
- ALPHA_DEPTHS, {16'd155,16'd120}: packed NUM_CH×16 vector; entry c is the alpha count of channel c, and each entry is ≤ NUM_SV.
- LOG_SV, `ceilLog2(NUM_SV): index width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- abort, in, 1: synchronous return to IDLE.
- load_start, in, 1: begin load sequence.
- wr_valid, in, 1: write beat valid.
- wr_ready, out, 1: write beat accepted.
- wr_support, in, NUM_CH*FEATS*NBITS: support row; channel c occupies bits [c*FEATS*NBITS +: FEATS*NBITS].
- wr_alpha, in, NUM_CH*NBITS: alpha per channel.
- load_done, out, 1: one-cycle pulse after the last row is written.
- rd_start, in, 1: begin stream.
- rd_valid, out, 1: stream beat valid.
- rd_ready, in, 1: consumer ready.
- rd_index, out, LOG_SV: support-vector index of the beat.
- rd_support, out, NUM_CH*FEATS*NBITS: support row.
- rd_alpha, out, NUM_CH*NBITS: alphas for the beat.
- rd_last, out, 1: beat index == NUM_SV-1.
- busy, out, 1: state != IDLE.

Behaviour:
- Reset (rst low, async): state IDLE, addresses 0, output buffer empty. All outputs are 0.
- Memory: behavioural single-port arrays with 1-cycle read latency. One support array holds NUM_SV rows. One alpha array per channel.
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - load_start → LOAD, wr_addr=0.
  - Else rd_start → STREAM, rd_addr=0.
  - If both are high, load wins.
- LOAD:
  - wr_ready=1.
  - On wr_valid&&wr_ready: write the support row at wr_addr. For each channel c, write the alpha only if wr_addr < ALPHA_DEPTHS[c]; out-of-range alpha writes are dropped (never aliased to address 0). Then wr_addr++.
  - The beat at wr_addr==NUM_SV-1 → load_done=1 the next cycle, state IDLE.
  - load_start and rd_start are ignored in LOAD.
- STREAM:
  - Issues a read of rd_addr in any cycle where buffer occupancy plus in-flight reads < 2, then rd_addr++.
  - After issuing NUM_SV-1 → DRAIN.
- DRAIN: no new reads. Once the buffer is empty after the last beat's handshake → IDLE.
- Output buffer:
  - 2-entry FIFO; read data enters one cycle after issue.
  - rd_valid = buffer non-empty. The head drives rd_index, rd_support, rd_alpha and rd_last.
  - Head pops on rd_valid&&rd_ready.
  - Outputs hold stable while rd_valid&&!rd_ready.
- Alpha readout: for each channel c, rd_alpha[c] = 0 when index ≥ ALPHA_DEPTHS[c], else the stored value.
- Latency and throughput:
  - rd_start sampled at edge T → address 0 issued in cycle T+1 → rd_valid in cycle T+2.
  - With rd_ready held high: 1 beat/cycle, NUM_SV beats in NUM_SV+1 cycles after T.
- abort (any state) → IDLE next edge. The buffer is flushed and rd_valid and wr_ready drop. No load_done is issued. Memory contents already written are retained.
- Reset mid-operation: same as abort, plus all outputs return to 0.
- rd_start while STREAM/DRAIN is ignored.
- Uninitialised reads return X in simulation; contents are valid only after a completed load.

Test Plan:
- Load rows r=0..213 with support word k of channel c = (r+k+c) mod 256 and alpha[c]=r, wr_valid held high → wr_ready high for 214 cycles; load_done pulses exactly once, at cycle 215.
- Stream after the load with rd_ready=1 → rd_valid first rises 2 cycles after rd_start; 214 consecutive beats; rd_index 0..213; rd_last only on 213.
- In the same stream, alpha gating → index 119: ch0 alpha=119, ch1=119. Index 120: ch0=0, ch1=120. Index 155: both 0.
- Random rd_ready with 40% duty → no beat lost or duplicated; payload stable while stalled; buffer never exceeds 2 entries.
- abort at stream beat 50, then rd_start again → rd_valid drops next cycle; the new stream restarts at index 0 with data intact.
- load_start and rd_start asserted together in IDLE → LOAD entered; rd_valid stays 0. Reset pulse mid-load at row 100 → busy=0 and load_done not asserted.
